// File: rtl/eth_rx_pkt_fifo_if.sv
// Bus bundle for eth_rx_pkt_fifo.
//   Eth_Byte_In        tagged input byte {SOP, EOP, data}
//   Eth_Byte_Valid_In  input qualifier (no backpressure)
//   M_Data/M_Last      output byte and end-of-packet marker
//   M_Valid/M_Ready    output handshake
//   Pkt_Avail          a committed packet is not yet fully read
//   Drop_Pulse         one cycle per dropped packet
//   Drop_Cnt           saturating dropped-packet count
// The slave modport is the FIFO's view; master is the surrounding logic.
interface eth_rx_pkt_fifo_if;
  logic [9:0]  Eth_Byte_In;
  logic        Eth_Byte_Valid_In;
  logic [7:0]  M_Data;
  logic        M_Valid;
  logic        M_Last;
  logic        M_Ready;
  logic        Pkt_Avail;
  logic        Drop_Pulse;
  logic [15:0] Drop_Cnt;

  modport slave (
    input  Eth_Byte_In, Eth_Byte_Valid_In, M_Ready,
    output M_Data, M_Valid, M_Last, Pkt_Avail, Drop_Pulse, Drop_Cnt
  );

  modport master (
    output Eth_Byte_In, Eth_Byte_Valid_In, M_Ready,
    input  M_Data, M_Valid, M_Last, Pkt_Avail, Drop_Pulse, Drop_Cnt
  );
endinterface

// File: rtl/eth_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO. Bytes are written speculatively and only become
// readable once their packet has ended cleanly; aborted or overflowing packets are
// rolled back to the last committed point and counted as drops.
// Ports:
//   Clk   clock
//   Rst   synchronous active-high reset (clears everything, including committed data)
//   bus   eth_rx_pkt_fifo_if.slave: tagged input stream, byte-wide valid/ready output
//         with last marker, Pkt_Avail, Drop_Pulse, Drop_Cnt
module eth_rx_pkt_fifo #(
  parameter int unsigned pDepth = 2048
) (
  input logic               Clk,
  input logic               Rst,
  eth_rx_pkt_fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(pDepth);
  typedef logic [AW:0] ptr_t;

  // StLast: the held byte is known to be the final byte of its packet.
  typedef enum logic [1:0] {StIdle, StRecv, StLast, StDiscard} state_e;

  state_e      state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        cm_ptr_q, cm_ptr_d;
  ptr_t        cm_rd_q;
  ptr_t        rd_ptr_q;
  logic [7:0]  hold_q, hold_d;
  logic        drop_q, drop_d;
  logic [15:0] drop_cnt_q;

  logic [8:0]  ram [pDepth];
  logic        wr_req, ram_we;
  logic [8:0]  ram_wdata;

  logic        in_v, in_sop, in_eop;
  logic [7:0]  in_data;
  logic        full;

  logic [7:0]  m_data_q;
  logic        m_valid_q, m_last_q;
  logic        rd_load;

  assign in_v    = bus.Eth_Byte_Valid_In;
  assign in_sop  = bus.Eth_Byte_In[9];
  assign in_eop  = bus.Eth_Byte_In[8];
  assign in_data = bus.Eth_Byte_In[7:0];

  // Uses the pre-edge read pointer, so a same-cycle read never frees space early.
  assign full = (wr_ptr_q - rd_ptr_q) == ptr_t'(pDepth);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    hold_d    = hold_q;
    drop_d    = 1'b0;
    wr_req    = 1'b0;
    ram_wdata = {1'b0, hold_q};

    unique case (state_q)
      StIdle, StDiscard: begin
        if (in_v && in_sop && in_eop) begin
          wr_req    = 1'b1;
          ram_wdata = {1'b1, in_data};
          state_d   = StIdle;
        end else if (in_v && in_sop) begin
          hold_d  = in_data;
          state_d = StRecv;
        end else if (!in_v || in_eop) begin
          state_d = StIdle;
        end
      end
      StRecv: begin
        if (!in_v) begin
          wr_req    = 1'b1;
          ram_wdata = {1'b1, hold_q};
          state_d   = StIdle;
        end else if (in_sop) begin
          // Abort the open packet; the new byte starts a fresh one.
          wr_ptr_d = cm_ptr_q;
          drop_d   = 1'b1;
          hold_d   = in_data;
          state_d  = in_eop ? StLast : StRecv;
        end else begin
          wr_req = 1'b1;
          hold_d = in_data;
          if (full) state_d = in_eop ? StIdle : StDiscard;
          else      state_d = in_eop ? StLast : StRecv;
        end
      end
      StLast: begin
        wr_req    = 1'b1;
        ram_wdata = {1'b1, hold_q};
        if (in_v && in_sop) begin
          hold_d  = in_data;
          state_d = in_eop ? StLast : StRecv;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    ram_we = wr_req && !full;
    if (wr_req) begin
      if (full) begin
        wr_ptr_d = cm_ptr_q;
        drop_d   = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (ram_wdata[8]) cm_ptr_d = wr_ptr_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      cm_rd_q    <= '0;
      hold_q     <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      // Read side sees commits one cycle late, giving the RAM write a cycle to land.
      cm_rd_q  <= cm_ptr_q;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
      if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (ram_we) ram[wr_ptr_q[AW-1:0]] <= ram_wdata;
  end

  // Registered FWFT output stage.
  assign rd_load = (rd_ptr_q != cm_rd_q) && (!m_valid_q || bus.M_Ready);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_ptr_q  <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (rd_load) begin
      {m_last_q, m_data_q} <= ram[rd_ptr_q[AW-1:0]];
      m_valid_q            <= 1'b1;
      rd_ptr_q             <= rd_ptr_q + ptr_t'(1);
    end else if (bus.M_Ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.M_Data     = m_data_q;
  assign bus.M_Last     = m_last_q;
  assign bus.M_Valid    = m_valid_q;
  assign bus.Pkt_Avail  = (cm_ptr_q != rd_ptr_q) || m_valid_q;
  assign bus.Drop_Pulse = drop_q;
  assign bus.Drop_Cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_pkt_fifo.sv
// Bench for eth_rx_pkt_fifo (pDepth=64): directed scenarios followed by random bursts,
// checked against a packet-level model of which packets survive.
module tb_eth_rx_pkt_fifo;
  localparam int unsigned Depth = 64;
  localparam int KNormal = 0;    // ends with EOP
  localparam int KValidEnd = 1;  // ends with a valid-low cycle
  localparam int KAbort = 2;     // cut short by the next packet's SOP

  logic Clk = 1'b0;
  logic Rst;

  eth_rx_pkt_fifo_if bus ();

  eth_rx_pkt_fifo #(.pDepth(Depth)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  int         exp_drops;
  int         seen_drops;
  int         seen_lasts;
  int         rdy_mode;
  logic       stall_q;
  logic [8:0] stall_val;
  int         lat;
  int         lasts0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle, before the edge that would accept the current output.
  task automatic observe();
    logic [8:0] e;
    if (stall_q) begin
      check("stall_valid", 32'(bus.M_Valid), 32'd1);
      check("stall_data", 32'({bus.M_Last, bus.M_Data}), 32'(stall_val));
    end
    if (bus.M_Valid === 1'b1 && bus.M_Ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(bus.M_Valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_byte", 32'({bus.M_Last, bus.M_Data}), 32'(e));
      end
      if (bus.M_Last === 1'b1) seen_lasts++;
    end
    if (bus.Drop_Pulse === 1'b1) seen_drops++;
    stall_q   = (bus.M_Valid === 1'b1) && (bus.M_Ready === 1'b0);
    stall_val = {bus.M_Last, bus.M_Data};
  endtask

  task automatic cycle(input logic v, input logic [9:0] w);
    bus.Eth_Byte_Valid_In = v;
    bus.Eth_Byte_In       = w;
    case (rdy_mode)
      0:       bus.M_Ready = 1'b1;
      1:       bus.M_Ready = ~bus.M_Ready;
      default: bus.M_Ready = ($urandom_range(0, 3) != 0);
    endcase
    observe();
    @(posedge Clk);
    #1;
  endtask

  // Drives one packet and records what the FIFO must do with it: aborted packets and
  // packets longer than the (empty) buffer are dropped, everything else is emitted.
  task automatic send_pkt(input int kind, input int len, input bit rnd, input logic [7:0] base);
    logic [7:0] bytes[$];
    logic [7:0] d;
    logic       eop;
    for (int i = 0; i < len; i++) begin
      d   = rnd ? 8'($urandom) : base + 8'(i);
      eop = (kind == KNormal) && (i == len - 1);
      cycle(1'b1, {(i == 0), eop, d});
      bytes.push_back(d);
    end
    if (kind == KValidEnd) cycle(1'b0, 10'h0);
    if (kind == KAbort || len > int'(Depth)) begin
      exp_drops++;
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), bytes[i]});
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 10'h0);
    while ((bus.Pkt_Avail !== 1'b0 || exp_q.size() != 0) && n < 400) begin
      cycle(1'b0, 10'h0);
      n++;
    end
    check({tag, "_pkt_avail"}, 32'(bus.Pkt_Avail), 32'd0);
    check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_drop_cnt"}, 32'(bus.Drop_Cnt), 32'(exp_drops));
    check({tag, "_drop_pulses"}, 32'(seen_drops), 32'(exp_drops));
  endtask

  initial begin
    Rst                   = 1'b1;
    bus.Eth_Byte_Valid_In = 1'b0;
    bus.Eth_Byte_In       = 10'h0;
    bus.M_Ready           = 1'b0;
    rdy_mode              = 0;
    stall_q               = 1'b0;
    exp_drops             = 0;
    seen_drops            = 0;
    seen_lasts            = 0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_m_valid", 32'(bus.M_Valid), 32'd0);
    check("rst_m_last", 32'(bus.M_Last), 32'd0);
    check("rst_m_data", 32'(bus.M_Data), 32'd0);
    check("rst_pkt_avail", 32'(bus.Pkt_Avail), 32'd0);
    check("rst_drop_pulse", 32'(bus.Drop_Pulse), 32'd0);
    check("rst_drop_cnt", 32'(bus.Drop_Cnt), 32'd0);
    Rst = 1'b0;
    cycle(1'b0, 10'h0);

    // Nominal 64-byte packet, fills the buffer exactly; check first-output latency.
    rdy_mode = 0;
    send_pkt(KNormal, 64, 1'b0, 8'h00);
    lat = -1;
    for (int i = 0; i <= 8; i++) begin
      if (bus.M_Valid === 1'b1) begin
        lat = i;
        break;
      end
      cycle(1'b0, 10'h0);
    end
    check("nominal_latency", 32'(lat), 32'd3);
    drain("nominal");

    // Back-to-back packets with no idle gap.
    lasts0 = seen_lasts;
    send_pkt(KNormal, 20, 1'b0, 8'h40);
    send_pkt(KNormal, 20, 1'b0, 8'h60);
    send_pkt(KNormal, 20, 1'b0, 8'h80);
    drain("b2b");
    check("b2b_last_count", 32'(seen_lasts - lasts0), 32'd3);

    // Overflow, then a normal packet.
    send_pkt(KNormal, 100, 1'b1, 8'h00);
    send_pkt(KNormal, 10, 1'b0, 8'hA0);
    drain("overflow");

    // One byte over the buffer size must drop.
    send_pkt(KNormal, 65, 1'b1, 8'h00);
    drain("over_by_one");

    // Early SOP abort.
    send_pkt(KAbort, 5, 1'b0, 8'h10);
    send_pkt(KNormal, 12, 1'b0, 8'hC0);
    drain("early_sop");

    // Valid-low termination, and a single-byte packet.
    send_pkt(KValidEnd, 15, 1'b0, 8'h30);
    send_pkt(KNormal, 1, 1'b0, 8'h5A);
    drain("valid_end");

    // Toggling backpressure.
    rdy_mode = 1;
    send_pkt(KNormal, 30, 1'b1, 8'h00);
    send_pkt(KValidEnd, 7, 1'b1, 8'h00);
    drain("toggle");

    // Random bursts; each burst fits the buffer unless a lone packet is oversized.
    for (int b = 0; b < 30; b++) begin
      int np;
      int kind;
      int len;
      bit big;
      rdy_mode = int'($urandom_range(0, 2));
      big      = ($urandom_range(0, 5) == 0);
      np       = big ? 1 : int'($urandom_range(1, 3));
      for (int p = 0; p < np; p++) begin
        kind = (p < np - 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 1));
        len  = big ? int'($urandom_range(Depth - 2, Depth + 40)) : int'($urandom_range(1, 20));
        send_pkt(kind, len, 1'b1, 8'h00);
        if (kind != KAbort) begin
          for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
            if ($urandom_range(0, 1) == 0) cycle(1'b0, 10'h0);
            else cycle(1'b1, {1'b0, 1'($urandom), 8'($urandom)});
          end
        end
      end
      drain("rand");
    end

    // Reset in the middle of reading.
    rdy_mode = 1;
    send_pkt(KNormal, 40, 1'b0, 8'h00);
    send_pkt(KNormal, 8, 1'b0, 8'h80);
    for (int i = 0; i < 12; i++) cycle(1'b0, 10'h0);
    check("pre_reset_valid", 32'(bus.M_Valid), 32'd1);
    Rst = 1'b1;
    cycle(1'b0, 10'h0);
    Rst = 1'b0;
    exp_q.delete();
    exp_drops  = 0;
    seen_drops = 0;
    stall_q    = 1'b0;
    check("post_reset_valid", 32'(bus.M_Valid), 32'd0);
    check("post_reset_pkt_avail", 32'(bus.Pkt_Avail), 32'd0);
    check("post_reset_drop_cnt", 32'(bus.Drop_Cnt), 32'd0);
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) cycle(1'b0, 10'h0);
    check("post_reset_quiet", 32'(bus.M_Valid), 32'd0);
    send_pkt(KNormal, 6, 1'b0, 8'hE0);
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
